// File: rtl/ibuf_multi_pkg.sv
// Shared types for the fetch-to-decode instruction buffer: exception codes,
// the NOP substituted for faulting fetches, and the stored entry layout.
package ibuf_multi_pkg;

  typedef enum logic [3:0] {
    EXC_NONE = 4'd0,
    EXC_INT  = 4'd1,
    EXC_ADEF = 4'd2,
    EXC_ADEM = 4'd3,
    EXC_ALE  = 4'd4,
    EXC_SYS  = 4'd5,
    EXC_BRK  = 4'd6,
    EXC_INE  = 4'd7,
    EXC_IPE  = 4'd8
  } exception_t;

  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exc;
    exception_t  exc_type;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_multi.sv
// Circular instruction buffer: up to IN_W writes and OUT_W reads per cycle, strict program order.
// Write-to-read latency 1 cycle (no bypass); in_ready reserves room for INFLIGHT outstanding groups.
module ibuf_multi
  import ibuf_multi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 2,
  parameter int INFLIGHT = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              flush,
  input  logic [$clog2(IN_W+1)-1:0]         in_count,
  output logic                              in_ready,
  input  logic [IN_W-1:0][31:0]             in_pc,
  input  logic [IN_W-1:0][31:0]             in_inst,
  input  logic [IN_W-1:0]                   in_pred_taken,
  input  logic [IN_W-1:0][31:0]             in_pred_target,
  input  logic [IN_W-1:0]                   in_exc,
  input  exception_t [IN_W-1:0]             in_exc_type,
  output logic [OUT_W-1:0]                  out_valid,
  output logic [OUT_W-1:0][31:0]            out_pc,
  output logic [OUT_W-1:0][31:0]            out_inst,
  output logic [OUT_W-1:0]                  out_pred_taken,
  output logic [OUT_W-1:0][31:0]            out_pred_target,
  output logic [OUT_W-1:0]                  out_exc,
  output exception_t [OUT_W-1:0]            out_exc_type,
  input  logic [$clog2(OUT_W+1)-1:0]        consume,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH+1);
  localparam int RDY_MAX = DEPTH - IN_W * (INFLIGHT + 1);

  ibuf_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err_ov;
  logic          r_err_un;

  logic [31:0]   w_count32;
  logic [31:0]   w_consume_req;
  logic [31:0]   w_in_req;
  logic [31:0]   w_consume_eff;
  logic [31:0]   w_free;
  logic [31:0]   w_wr_n;
  logic          w_underflow;
  logic          w_overflow;
  ibuf_entry_t   w_wr_entry [IN_W];

  // All occupancy arithmetic is done at 32 bits so nothing wraps before clamping.
  always_comb begin
    w_count32     = 32'(r_count);
    w_consume_req = 32'(consume);
    w_in_req      = 32'(in_count);
    w_underflow   = (w_consume_req > w_count32);
    w_consume_eff = w_underflow ? w_count32 : w_consume_req;
    w_free        = 32'(DEPTH) - w_count32 + w_consume_eff;
    w_overflow    = (w_in_req > w_free);
    w_wr_n        = w_overflow ? w_free : w_in_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_err_ov <= 1'b0;
      r_err_un <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_consume_eff);
      r_tail  <= r_tail + PW'(w_wr_n);
      r_count <= CW'(w_count32 + w_wr_n - w_consume_eff);
      if (w_overflow)  r_err_ov <= 1'b1;
      if (w_underflow) r_err_un <= 1'b1;
    end
  end

  for (genvar i = 0; i < IN_W; i++) begin : g_wr
    assign w_wr_entry[i] = '{pc:          in_pc[i],
                             inst:        in_inst[i],
                             pred_taken:  in_pred_taken[i],
                             pred_target: in_pred_target[i],
                             exc:         in_exc[i],
                             exc_type:    in_exc_type[i]};
  end

  // Payload RAM carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < IN_W; i++) begin
        if (32'(i) < w_wr_n) r_mem[r_tail + PW'(i)] <= w_wr_entry[i];
      end
    end
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_rd
    logic [PW-1:0] w_idx;
    ibuf_entry_t   w_ent;
    assign w_idx              = r_head + PW'(k);
    assign w_ent              = r_mem[w_idx];
    assign out_valid[k]       = (w_count32 > 32'(k));
    assign out_pc[k]          = w_ent.pc;
    assign out_inst[k]        = w_ent.exc ? INST_NOP : w_ent.inst;
    assign out_pred_taken[k]  = w_ent.pred_taken;
    assign out_pred_target[k] = w_ent.pred_target;
    assign out_exc[k]         = w_ent.exc;
    assign out_exc_type[k]    = w_ent.exc_type;
  end

  assign in_ready      = (w_count32 <= 32'(RDY_MAX));
  assign count         = r_count;
  assign err_overflow  = r_err_ov;
  assign err_underflow = r_err_un;

endmodule

// File: tb/tb_ibuf_multi.sv
// Scoreboard bench for ibuf_multi: stimulus queues expected observations, a negedge monitor checks them.
module tb_ibuf_multi;
  import ibuf_multi_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       in_count = '0;
  logic             in_ready;
  logic [1:0][31:0] in_pc = '0;
  logic [1:0][31:0] in_inst = '0;
  logic [1:0]       in_pred_taken = '0;
  logic [1:0][31:0] in_pred_target = '0;
  logic [1:0]       in_exc = '0;
  exception_t [1:0] in_exc_type = {EXC_NONE, EXC_NONE};
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_inst;
  logic [1:0]       out_pred_taken;
  logic [1:0][31:0] out_pred_target;
  logic [1:0]       out_exc;
  exception_t [1:0] out_exc_type;
  logic [1:0]       consume = '0;
  logic [3:0]       count;
  logic             err_overflow;
  logic             err_underflow;

  ibuf_multi dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_count(in_count), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_exc(in_exc), .in_exc_type(in_exc_type),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
    .out_exc(out_exc), .out_exc_type(out_exc_type),
    .consume(consume), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_CNT = 0, S_VLD = 1, S_RDY = 2, S_OV = 3, S_UN = 4, S_PC0 = 5,
                 S_PC1 = 6, S_INST0 = 7, S_INST1 = 8, S_EXC = 9, S_ETYPE1 = 10;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic exp_at(input int c, input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.cyc = c; e.name = name; e.sel = sel; e.val = val;
    q.push_back(e);
  endtask

  // Expectations for the state visible after the coming clock edge.
  task automatic nxt(input string name, input int sel, input logic [31:0] val);
    exp_at(cyc + 1, name, sel, val);
  endtask

  task automatic now(input string name, input int sel, input logic [31:0] val);
    exp_at(cyc, name, sel, val);
  endtask

  function automatic logic [31:0] act(input int sel);
    case (sel)
      S_CNT:    return 32'(count);
      S_VLD:    return 32'(out_valid);
      S_RDY:    return 32'(in_ready);
      S_OV:     return 32'(err_overflow);
      S_UN:     return 32'(err_underflow);
      S_PC0:    return out_pc[0];
      S_PC1:    return out_pc[1];
      S_INST0:  return out_inst[0];
      S_INST1:  return out_inst[1];
      S_EXC:    return 32'(out_exc);
      S_ETYPE1: return 32'(out_exc_type[1]);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    int i;
    logic [31:0] a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        a = act(q[i].sel);
        n_vec++;
        if (a !== q[i].val) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, a, q[i].val, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put2(input logic [31:0] pc0, input logic [31:0] i0,
                      input logic [31:0] pc1, input logic [31:0] i1,
                      input logic e1, input exception_t t1);
    in_pc          = {pc1, pc0};
    in_inst        = {i1, i0};
    in_pred_taken  = 2'b00;
    in_pred_target = {pc1 + 32'h40, pc0 + 32'h40};
    in_exc         = {e1, 1'b0};
    in_exc_type    = {t1, EXC_NONE};
    in_count       = 2'd2;
  endtask

  task automatic idle();
    in_count = 2'd0;
    consume  = 2'd0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", q.size());
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    now("reset_count", S_CNT, 0);
    now("reset_valid", S_VLD, 0);
    now("reset_ready", S_RDY, 1);
    now("reset_ov", S_OV, 0);
    now("reset_un", S_UN, 0);
    tick();

    put2(32'h1c00_0000, 32'h0000_0011, 32'h1c00_0004, 32'h0000_0022, 1'b0, EXC_NONE);
    nxt("single_valid", S_VLD, 3);
    nxt("single_pc0", S_PC0, 32'h1c00_0000);
    nxt("single_pc1", S_PC1, 32'h1c00_0004);
    nxt("single_count", S_CNT, 2);
    tick();

    put2(32'h1c00_0008, 32'h0000_0033, 32'h1c00_000c, 32'h0000_0044, 1'b0, EXC_NONE);
    nxt("fill_count4", S_CNT, 4);
    nxt("fill_ready4", S_RDY, 1);
    tick();
    put2(32'h1c00_0010, 32'h0000_0055, 32'h1c00_0014, 32'h0000_0066, 1'b0, EXC_NONE);
    nxt("fill_count6", S_CNT, 6);
    nxt("fill_ready6", S_RDY, 0);
    tick();
    idle();
    consume = 2'd1;
    nxt("drain_count5", S_CNT, 5);
    nxt("drain_ready5", S_RDY, 0);
    tick();
    nxt("drain_count4", S_CNT, 4);
    nxt("drain_ready4", S_RDY, 1);
    nxt("drain_head_pc", S_PC0, 32'h1c00_0008);
    tick();
    consume = 2'd2;
    tick();
    nxt("drain_empty", S_CNT, 0);
    tick();

    idle();
    put2(32'h1c00_1000, 32'h1, 32'h1c00_1004, 32'h2, 1'b0, EXC_NONE);
    nxt("stream_prime", S_CNT, 2);
    tick();
    for (int j = 1; j <= 10; j++) begin
      put2(32'h1c00_1000 + 32'(8 * j), 32'(j), 32'h1c00_1004 + 32'(8 * j), 32'(j + 100), 1'b0, EXC_NONE);
      consume = 2'd2;
      nxt($sformatf("stream_count_%0d", j), S_CNT, 2);
      nxt($sformatf("stream_pc0_%0d", j), S_PC0, 32'h1c00_1000 + 32'(8 * j));
      nxt($sformatf("stream_pc1_%0d", j), S_PC1, 32'h1c00_1004 + 32'(8 * j));
      tick();
    end
    in_count = 2'd0;
    nxt("stream_drain", S_CNT, 0);
    tick();

    idle();
    put2(32'h1c00_2000, 32'h0280_0421, 32'h1c00_2004, 32'h1234_5678, 1'b1, EXC_ADEF);
    nxt("exc_inst0", S_INST0, 32'h0280_0421);
    nxt("exc_inst1_nop", S_INST1, 32'h0340_0000);
    nxt("exc_bits", S_EXC, 2);
    nxt("exc_type1", S_ETYPE1, 32'(EXC_ADEF));
    tick();
    idle();
    consume = 2'd2;
    nxt("exc_drain", S_CNT, 0);
    tick();

    idle();
    flush = 1'b1;
    put2(32'h1c00_3000, 32'h5, 32'h1c00_3004, 32'h6, 1'b0, EXC_NONE);
    nxt("flush_count", S_CNT, 0);
    nxt("flush_valid", S_VLD, 0);
    tick();
    idle();
    consume = 2'd1;
    nxt("under_flag", S_UN, 1);
    nxt("under_count", S_CNT, 0);
    nxt("under_no_ov", S_OV, 0);
    tick();
    idle();
    for (int j = 0; j < 4; j++) begin
      put2(32'h1c00_4000 + 32'(8 * j), 32'h7, 32'h1c00_4004 + 32'(8 * j), 32'h8, 1'b0, EXC_NONE);
      tick();
    end
    in_count = 2'd0;
    now("full_count", S_CNT, 8);
    put2(32'h1c00_5000, 32'h9, 32'h1c00_5004, 32'ha, 1'b0, EXC_NONE);
    nxt("over_flag", S_OV, 1);
    nxt("over_count", S_CNT, 8);
    nxt("over_head_kept", S_PC0, 32'h1c00_4000);
    nxt("under_sticky", S_UN, 1);
    tick();
    idle();
    flush = 1'b1;
    nxt("flush_keeps_ov", S_OV, 1);
    nxt("flush_keeps_un", S_UN, 1);
    nxt("flush_full_count", S_CNT, 0);
    tick();
    idle();
    tick();
    tick();

    if (q.size() != 0) begin
      n_vec += q.size();
      n_err += q.size();
      $display("FAIL pending: got %0d unchecked expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibuf_multi.md
Name: ibuf_multi

Overview:
- Parametrised instruction buffer between fetch and decode. Generalises the 2-in/2-out fetch buffer to IN_W fetch lanes, OUT_W decode lanes and a power-of-two DEPTH.
- Adds per-entry exception capture with NOP substitution, a configurable in-flight reservation for `in_ready`, and sticky overflow/underflow error flags for verification.
- Circular queue; entries leave in strict program order.

Parameters:
- DEPTH, 8: entry count; must be a power of two and ≥ IN_W*(INFLIGHT+1).
- IN_W, 2: maximum instructions written per cycle.
- OUT_W, 2: maximum instructions presented and consumed per cycle.
- INFLIGHT, 1: number of outstanding fetch groups that `in_ready` must leave room for.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear (redirect)
- in_count  in  $clog2(IN_W+1)  number of valid lanes this cycle, packed from lane 0
- in_ready  out  1  buffer can accept a new fetch request
- in_pc  in  IN_W×32  per-lane PC
- in_inst  in  IN_W×32  per-lane instruction
- in_pred_taken  in  IN_W  per-lane predicted taken
- in_pred_target  in  IN_W×32  per-lane predicted target
- in_exc  in  IN_W  per-lane fetch exception
- in_exc_type  in  IN_W×exception_t  per-lane exception code
- out_valid  out  OUT_W  thermometer code; lane k valid iff count > k
- out_pc / out_inst / out_pred_taken / out_pred_target / out_exc / out_exc_type  out  OUT_W×(as input)  entry at head+k
- consume  in  $clog2(OUT_W+1)  number of head entries decode takes this cycle
- count  out  $clog2(DEPTH+1)  current occupancy
- err_overflow  out  1  sticky; a write exceeded free space
- err_underflow  out  1  sticky; `consume` exceeded occupancy

Behaviour:
- Reset (asynchronous, resetn=0):
  - head=0, tail=0, count=0.
  - out_valid=0, in_ready=1, err_overflow=0, err_underflow=0.
  - Payload RAM is not reset.
- in_ready = (count ≤ DEPTH − IN_W*(INFLIGHT+1)). Combinational from registered count.
- Write (not flush):
  - Lanes 0..in_count−1 are written to tail+i mod DEPTH; tail += in_count.
  - The entry stores pc, inst, pred_taken, pred_target, exc and exc_type.
- Read:
  - out_* lane k = entry[(head+k) mod DEPTH], combinational from storage.
  - If the entry's exc=1, out_inst reads 32'h03400000 (NOP); the stored inst is not modified.
- Consume: head += consume, applied on the same edge as the write.
- Latency: a written entry is visible on out_* on the cycle after the write. There is no same-cycle bypass.
- Next count = count + in_count − consume, computed at full width with no wrap.
- Simultaneous write and consume: both apply. Free space for the write is DEPTH − count + consume.
- Overflow (in_count > DEPTH − count + consume):
  - Set err_overflow.
  - Write only the lanes that fit; tail and count saturate at DEPTH.
- Underflow (consume > count):
  - Set err_underflow.
  - Treat the effective consume as count.
- Wrap-around: pointer width is $clog2(DEPTH); arithmetic is modulo DEPTH.
- flush=1:
  - Clears head, tail and count at the edge.
  - Same-cycle in_count and consume are ignored.
  - Error flags are kept.
- Error flags clear only on reset.
- Decode sees exc on lane 0 only for the oldest instruction. Younger lanes carry their own exc bit, so decode does not rely on buffer-wide state.

Decomposition:
- Shared package (definitions.svh): exception_t (existing), constant INST_NOP = 32'h03400000, and a packed struct ibuf_entry_t {pc, inst, pred_taken, pred_target, exc, exc_type}.
- Storage is an array of ibuf_entry_t.
- No sub-module; pointer/count logic stays inline, roughly 200 lines.

Test Plan:
- Reset then idle: after resetn rises, count=0, out_valid=00, in_ready=1, both error flags 0.
- Single write, no consume: in_count=2 with pc 0x1c000000 and 0x1c000004 → next cycle out_valid=11, out_pc = those values, count=2.
- Fill, then check ready: defaults DEPTH=8, IN_W=2, INFLIGHT=1; three writes of 2 with no consume → in_ready=1 at count=4, in_ready=0 at count=6. Drain with consume=1 ×2 → in_ready returns to 1 at count=4.
- Wrap plus simultaneous traffic:
  - Stream 2 in / 2 out for 10 cycles.
  - PCs increment by 4; out_pc follows the sequence with no gaps.
  - count stays 2; tail wraps 6→0.
- Exception NOP:
  - Write lane 0 with inst=0x02800421, exc=0, and lane 1 with inst=0x12345678, exc=1, type=ADEF.
  - Result: out_inst[0]=0x02800421, out_inst[1]=0x03400000, out_exc=10 (lane 1 set), exc_type=ADEF.
- Flush, underflow and overflow:
  - flush together with in_count=2 → count=0 next cycle; the written data is discarded.
  - consume=1 at count=0 → err_underflow=1; count stays 0.
  - Writing 2 when count=8 → err_overflow=1; count stays 8.
